seq_onehot_decoder: RTL and testbench
=====================================

// Module: seq_onehot_decoder
// PURPOSE
//  Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with a built-in sweep sequencer.
//  DIRECT mode decodes handshaked select codes. SWEEP mode walks every code 0..2^SEL_W-1, holding each for DWELL cycles.
//  Drives LED/segment/row-select fabric and replaces hand-driven select stimulus in lab tops.
// PARAMETERS
//  SEL_W       3   select width; output width OUT_W = 2**SEL_W (1..6)
//  DWELL       50  cycles each code is held in SWEEP (>=1)
//  ACTIVE_LOW  0   1: selected line is 0, idle lines 1 (inactive level = all ones)
//  LOOP        0   1: SWEEP wraps to code 0 forever; 0: single pass then stop
//  BIT_REV     0   1: output bit order reversed (code k drives dout[OUT_W-1-k])
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      synchronous reset, active-high
//  en          in   1      block enable; low forces inactive outputs
//  mode        in   1      0 = DIRECT, 1 = SWEEP
//  sel_valid   in   1      DIRECT: sel is presented
//  sel         in   SEL_W  DIRECT: code to decode
//  sel_ready   out  1      DIRECT: block accepts sel this cycle
//  dout        out  OUT_W  registered one-hot (or one-cold) output
//  cur_sel     out  SEL_W  code currently driven on dout
//  dout_valid  out  1      dout holds a decoded code (not idle level)
//  sweep_done  out  1      1-cycle pulse when the last code's dwell completes
// BEHAVIOUR
//  Reset: state=IDLE; dout=inactive level; cur_sel=0; dout_valid=0; sweep_done=0; dwell_cnt=0.
//  Reset has priority over everything. en=0 has priority over mode/sel_valid.
//  FSM states: IDLE, HOLD, SWEEP, DONE.
//  IDLE: dout inactive; dout_valid=0.
//    en & !mode -> HOLD.
//    en & mode  -> SWEEP, with cur_sel=0 and dwell_cnt=0.
//  HOLD (DIRECT): sel_ready = en & !mode (combinational, also high in IDLE when en & !mode).
//    Accept = sel_valid & sel_ready.
//    Latency 1: accepted code appears on dout/cur_sel on the next edge; dout_valid=1 from then on.
//    With no new accept, dout holds the last code indefinitely; back-to-back accepts every cycle are legal.
//  SWEEP: sel_ready=0; sel and sel_valid are ignored. dout=decode(cur_sel), dout_valid=1.
//    dwell_cnt counts 0..DWELL-1; at DWELL-1 it clears and cur_sel increments.
//    Last code (all ones) at DWELL-1:
//      LOOP=1: cur_sel wraps to 0, sweep_done pulses, stay in SWEEP.
//      LOOP=0: sweep_done pulses, go to DONE.
//    DWELL=1 advances one code per cycle, so a full pass = OUT_W cycles.
//  DONE: dout inactive, dout_valid=0.
//    Stays until en=0 or mode=0, which return to IDLE; no re-trigger while en & mode stay high.
//  Any state with en=0 -> IDLE next edge; outputs inactive, cur_sel=0, dwell_cnt=0.
//  mode toggled mid-operation: abort the current activity, go IDLE for one cycle, then re-enter per IDLE rules.
//    Partial sweep progress is discarded.
//  Width rules: dwell_cnt width = $clog2(DWELL+1). cur_sel wraps modulo 2**SEL_W.
//  Exactly one line is active whenever dout_valid=1; none when dout_valid=0.
// STRUCTURE
//  decoder_pkg: state encoding localparams (IDLE/HOLD/SWEEP/DONE), MODE_DIRECT/MODE_SWEEP constants,
//    and function inactive_level(OUT_W, ACTIVE_LOW).
//  Sub-module onehot_dec (combinational, params SEL_W/ACTIVE_LOW/BIT_REV): sel -> one-hot/one-cold word.
//    The top registers its output.
//  Top holds FSM, dwell counter, cur_sel register, output register.
// TESTING
//  1 Reset: rst=1 for 2 cycles with en=1 -> dout=8'h00, dout_valid=0, sel_ready=0 during reset (SEL_W=3, ACTIVE_LOW=0).
//  2 DIRECT: en=1, mode=0, present sel=5 with valid -> next cycle dout=8'h20, cur_sel=5;
//    sel=0 on the following cycle -> dout=8'h01; drop valid -> dout holds 8'h01.
//  3 SWEEP single pass, DWELL=3: en=1, mode=1 -> dout steps 01,02,04..80, each held 3 cycles.
//    sweep_done high exactly once, at cycle 24 after entry. Then DONE with dout=00 while en/mode stay high.
//  4 SWEEP LOOP=1, DWELL=1: dout walks 01..80 then 01 again; sweep_done pulses every 8 cycles.
//  5 Abort: mid-sweep at cur_sel=3, drop en -> next edge dout=00, cur_sel=0.
//    Raise en with mode=1 -> IDLE, then sweep restarts from code 0.
//  6 Variants: ACTIVE_LOW=1, BIT_REV=1, SEL_W=4, DIRECT sel=2 -> dout=16'hDFFF (bit 13 low); idle level 16'hFFFF.

Source files
------------

// File: rtl/seq_onehot_decoder_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder: FSM state encoding,
// mode constants and the idle (inactive) output level.
package seq_onehot_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    // Widest output supported (SEL_W up to 6).
    localparam int MAX_OUT_W = 64;

    // Level driven on dout when no code is selected: all zeros, or all ones
    // across the used OUT_W bits when the output is active-low.
    function automatic logic [MAX_OUT_W-1:0] inactive_level(input int out_w, input bit active_low);
        logic [MAX_OUT_W-1:0] lvl;
        lvl = '0;
        if (active_low) begin
            for (int i = 0; i < MAX_OUT_W; i++) begin
                if (i < out_w) begin
                    lvl[i] = 1'b1;
                end
            end
        end
        return lvl;
    endfunction

endpackage

// File: rtl/seq_onehot_decoder_onehot_dec.sv
// Combinational SEL_W-to-2^SEL_W decoder producing a one-hot or one-cold word,
// optionally with the bit order reversed.
module seq_onehot_decoder_onehot_dec #(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit BIT_REV    = 1'b0
) (
    input  logic [SEL_W-1:0]      sel_i,
    output logic [(2**SEL_W)-1:0] word_o
);

    localparam int OUT_W = 2**SEL_W;

    logic [SEL_W-1:0] idx;
    logic [OUT_W-1:0] word;

    always_comb begin
        // Reversing the bit order maps code k to OUT_W-1-k, which is ~k in SEL_W bits.
        idx       = BIT_REV ? ~sel_i : sel_i;
        word      = '0;
        word[idx] = 1'b1;
        word_o    = ACTIVE_LOW ? ~word : word;
    end

endmodule

// File: rtl/seq_onehot_decoder.sv
// Registered one-hot decoder with two sources for the code: handshaked DIRECT
// selects, or a built-in SWEEP that walks every code holding each for DWELL cycles.
module seq_onehot_decoder
    import seq_onehot_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 50,
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit LOOP       = 1'b0,
    parameter bit BIT_REV    = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic                  sel_valid_i,
    input  logic [SEL_W-1:0]      sel_i,
    output logic                  sel_ready_o,
    output logic [(2**SEL_W)-1:0] dout_o,
    output logic [SEL_W-1:0]      cur_sel_o,
    output logic                  dout_valid_o,
    output logic                  sweep_done_o,
    output logic [1:0]            state_o
);

    localparam int OUT_W   = 2**SEL_W;
    localparam int DWELL_W = $clog2(DWELL + 1);

    localparam logic [MAX_OUT_W-1:0] IDLE_FULL  = inactive_level(OUT_W, ACTIVE_LOW);
    localparam logic [OUT_W-1:0]     IDLE_LVL   = IDLE_FULL[OUT_W-1:0];
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic [OUT_W-1:0]   dec_word;
    logic               accept;

    // Handshake: a code is transferred on a rising edge where sel_valid_i and
    // sel_ready_o are both high; ready is only offered out of reset, while enabled
    // in DIRECT mode and in IDLE/HOLD, and never depends on sel_valid_i.
    assign sel_ready_o = !rst_i && en_i && (mode_i == MODE_DIRECT)
                         && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign accept      = sel_valid_i && sel_ready_o;

    // Decode the code that will be current after this edge, so dout registers in step with cur_sel.
    seq_onehot_decoder_onehot_dec #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW),
        .BIT_REV    (BIT_REV)
    ) u_dec (
        .sel_i  (cur_sel_d),
        .word_o (dec_word)
    );

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        dwell_d   = dwell_q;
        valid_d   = valid_q;
        done_d    = 1'b0;

        if (!en_i) begin
            state_d   = ST_IDLE;
            cur_sel_d = '0;
            dwell_d   = '0;
            valid_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_i == MODE_DIRECT) begin
                        state_d = ST_HOLD;
                        if (accept) begin
                            cur_sel_d = sel_i;
                            valid_d   = 1'b1;
                        end
                    end else begin
                        state_d   = ST_SWEEP;
                        cur_sel_d = '0;
                        dwell_d   = '0;
                        valid_d   = 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (mode_i == MODE_SWEEP) begin
                        state_d   = ST_IDLE;
                        cur_sel_d = '0;
                        dwell_d   = '0;
                        valid_d   = 1'b0;
                    end else if (accept) begin
                        cur_sel_d = sel_i;
                        valid_d   = 1'b1;
                    end
                end

                ST_SWEEP: begin
                    if (mode_i == MODE_DIRECT) begin
                        // Abandon the sweep; progress is not kept.
                        state_d   = ST_IDLE;
                        cur_sel_d = '0;
                        dwell_d   = '0;
                        valid_d   = 1'b0;
                    end else if (dwell_q == DWELL_LAST) begin
                        dwell_d   = '0;
                        cur_sel_d = cur_sel_q + SEL_W'(1);
                        if (cur_sel_q == '1) begin
                            done_d = 1'b1;
                            if (!LOOP) begin
                                state_d   = ST_DONE;
                                cur_sel_d = '0;
                                valid_d   = 1'b0;
                            end
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end

                ST_DONE: begin
                    // Parked until en or mode drops, so a held SWEEP request cannot re-trigger.
                    if (mode_i == MODE_DIRECT) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    cur_sel_d = '0;
                    dwell_d   = '0;
                    valid_d   = 1'b0;
                end
            endcase
        end

        dout_d = valid_d ? dec_word : IDLE_LVL;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
            dwell_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= IDLE_LVL;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            dwell_q   <= dwell_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
        end
    end

    assign dout_o       = dout_q;
    assign cur_sel_o    = cur_sel_q;
    assign dout_valid_o = valid_q;
    assign sweep_done_o = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_seq_onehot_decoder.sv
// Bench for seq_onehot_decoder: three configurations (plain single pass, looping
// DWELL=1, and a 4-bit active-low bit-reversed variant) checked against an arithmetic model.
module tb_seq_onehot_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // A: SEL_W=3, DWELL=3, single pass
    logic       a_en = 1'b1, a_mode = 1'b0, a_sv = 1'b0;
    logic [2:0] a_sel = '0;
    logic       a_rdy, a_val, a_done;
    logic [7:0] a_dout;
    logic [2:0] a_cur;
    logic [1:0] a_st;
    // B: SEL_W=3, DWELL=1, looping
    logic       b_en = 1'b1, b_mode = 1'b0, b_sv = 1'b0;
    logic [2:0] b_sel = '0;
    logic       b_rdy, b_val, b_done;
    logic [7:0] b_dout;
    logic [2:0] b_cur;
    logic [1:0] b_st;
    // C: SEL_W=4, DWELL=2, active-low, bit-reversed, single pass
    logic        c_en = 1'b1, c_mode = 1'b0, c_sv = 1'b0;
    logic [3:0]  c_sel = '0;
    logic        c_rdy, c_val, c_done;
    logic [15:0] c_dout;
    logic [3:0]  c_cur;
    logic [1:0]  c_st;

    seq_onehot_decoder #(.SEL_W(3), .DWELL(3), .ACTIVE_LOW(1'b0), .LOOP(1'b0), .BIT_REV(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(a_en), .mode_i(a_mode), .sel_valid_i(a_sv), .sel_i(a_sel),
        .sel_ready_o(a_rdy), .dout_o(a_dout), .cur_sel_o(a_cur), .dout_valid_o(a_val),
        .sweep_done_o(a_done), .state_o(a_st));

    seq_onehot_decoder #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b0), .LOOP(1'b1), .BIT_REV(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(b_en), .mode_i(b_mode), .sel_valid_i(b_sv), .sel_i(b_sel),
        .sel_ready_o(b_rdy), .dout_o(b_dout), .cur_sel_o(b_cur), .dout_valid_o(b_val),
        .sweep_done_o(b_done), .state_o(b_st));

    seq_onehot_decoder #(.SEL_W(4), .DWELL(2), .ACTIVE_LOW(1'b1), .LOOP(1'b0), .BIT_REV(1'b1)) dut_c (
        .clk_i(clk), .rst_i(rst), .en_i(c_en), .mode_i(c_mode), .sel_valid_i(c_sv), .sel_i(c_sel),
        .sel_ready_o(c_rdy), .dout_o(c_dout), .cur_sel_o(c_cur), .dout_valid_o(c_val),
        .sweep_done_o(c_done), .state_o(c_st));

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] out_mask(input int sel_w);
        int out_w;
        out_w = 1 << sel_w;
        return (out_w == 64) ? {64{1'b1}} : ((64'd1 << out_w) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_idle(input int sel_w, input bit al);
        return al ? out_mask(sel_w) : 64'd0;
    endfunction

    // Line number k (or OUT_W-1-k reversed) is the active one; active-low inverts the word.
    function automatic logic [63:0] ref_word(input int code, input int sel_w, input bit al, input bit br);
        int out_w;
        int pos;
        logic [63:0] w;
        out_w = 1 << sel_w;
        pos   = br ? (out_w - 1 - code) : code;
        w     = 64'd1 << pos;
        return al ? (~w & out_mask(sel_w)) : w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // t = edges since the sweep-entry edge; expected code is floor(t/DWELL) mod OUT_W.
    task automatic check_sweep(input string tag, input int t, input int sel_w, input int dwell,
                               input bit loop, input bit al, input bit br, input logic [63:0] dout,
                               input logic [63:0] cur, input logic valid, input logic done);
        int  pass_len;
        bit  active;
        bit  exp_done;
        int  code;
        pass_len = (1 << sel_w) * dwell;
        active   = loop || (t < pass_len);
        exp_done = (t > 0) && (loop ? ((t % pass_len) == 0) : (t == pass_len));
        if (active) begin
            code = (t / dwell) % (1 << sel_w);
            check($sformatf("%s_dout_t%0d", tag, t), dout, ref_word(code, sel_w, al, br));
            check($sformatf("%s_cur_t%0d", tag, t), cur, 64'(code));
            check($sformatf("%s_valid_t%0d", tag, t), 64'(valid), 64'd1);
        end else begin
            check($sformatf("%s_dout_t%0d", tag, t), dout, ref_idle(sel_w, al));
            check($sformatf("%s_valid_t%0d", tag, t), 64'(valid), 64'd0);
        end
        check($sformatf("%s_done_t%0d", tag, t), 64'(done), 64'(exp_done));
    endtask

    initial begin
        logic [63:0] exp_code;
        int          done_cnt;
        int          abort_t;

        // Reset held two cycles with en high
        tick();
        tick();
        check("rst_dout_a", 64'(a_dout), ref_idle(3, 1'b0));
        check("rst_valid_a", 64'(a_val), 64'd0);
        check("rst_ready_a", 64'(a_rdy), 64'd0);
        check("rst_cur_a", 64'(a_cur), 64'd0);
        check("rst_done_a", 64'(a_done), 64'd0);
        check("rst_dout_c", 64'(c_dout), 64'hFFFF);
        rst  = 1'b0;
        a_en = 1'b0;
        b_en = 1'b0;
        c_en = 1'b0;
        tick();
        check("idle_dout_a", 64'(a_dout), 64'd0);

        // DIRECT directed steps on A
        a_en = 1'b1; a_mode = 1'b0; a_sv = 1'b1; a_sel = 3'd5;
        #1;
        check("direct_ready_idle", 64'(a_rdy), 64'd1);
        tick();
        check("direct_dout_5", 64'(a_dout), 64'h20);
        check("direct_cur_5", 64'(a_cur), 64'd5);
        check("direct_valid_5", 64'(a_val), 64'd1);
        a_sel = 3'd0;
        tick();
        check("direct_dout_0", 64'(a_dout), 64'h01);
        a_sv = 1'b0;
        tick();
        check("direct_hold_1", 64'(a_dout), 64'h01);
        tick();
        check("direct_hold_2", 64'(a_dout), 64'h01);
        check("direct_hold_valid", 64'(a_val), 64'd1);

        // DIRECT random accepts on A, scoreboarded with latency 1
        exp_code = 64'd0;
        repeat (40) begin
            a_sv  = 1'($urandom_range(0, 1));
            a_sel = 3'($urandom_range(0, 7));
            #1;
            check("rand_ready", 64'(a_rdy), 64'd1);
            if (a_sv) exp_q.push_back(64'(a_sel));
            tick();
            if (exp_q.size() > 0) exp_code = exp_q.pop_front();
            check("rand_dout", 64'(a_dout), ref_word(int'(exp_code), 3, 1'b0, 1'b0));
            check("rand_cur", 64'(a_cur), exp_code);
            check("rand_valid", 64'(a_val), 64'd1);
        end

        // en low wins over a pending select
        a_en = 1'b0; a_sv = 1'b1; a_sel = 3'd6;
        #1;
        check("en_low_ready", 64'(a_rdy), 64'd0);
        tick();
        check("en_low_dout", 64'(a_dout), 64'd0);
        check("en_low_valid", 64'(a_val), 64'd0);
        check("en_low_cur", 64'(a_cur), 64'd0);
        a_en = 1'b1; a_sv = 1'b0;
        tick();
        check("hold_noaccept_valid", 64'(a_val), 64'd0);
        check("hold_noaccept_dout", 64'(a_dout), 64'd0);
        a_sv = 1'b1; a_sel = 3'd6;
        tick();
        check("hold_dout_6", 64'(a_dout), 64'h40);

        // Mode toggle from DIRECT: one idle cycle, then a single-pass sweep with DWELL=3
        a_sv = 1'b0; a_mode = 1'b1;
        tick();
        check("toggle_idle_dout", 64'(a_dout), 64'd0);
        check("toggle_idle_valid", 64'(a_val), 64'd0);
        check("toggle_idle_ready", 64'(a_rdy), 64'd0);
        tick();
        done_cnt = 0;
        for (int t = 0; t <= 30; t++) begin
            check_sweep("sweep_a", t, 3, 3, 1'b0, 1'b0, 1'b0, 64'(a_dout), 64'(a_cur), a_val, a_done);
            done_cnt += int'(a_done);
            a_sv  = 1'($urandom_range(0, 1));
            a_sel = 3'($urandom_range(0, 7));
            #1;
            check("sweep_a_ready", 64'(a_rdy), 64'd0);
            if (t < 30) tick();
        end
        check("sweep_a_done_count", 64'(done_cnt), 64'd1);
        a_mode = 1'b0; a_sv = 1'b0;
        tick();
        check("done_exit_valid", 64'(a_val), 64'd0);

        // Looping sweep on B, DWELL=1; abort at code 3 and restart
        b_en = 1'b1; b_mode = 1'b1;
        tick();
        done_cnt = 0;
        for (int t = 0; t <= 27; t++) begin
            check_sweep("loop_b", t, 3, 1, 1'b1, 1'b0, 1'b0, 64'(b_dout), 64'(b_cur), b_val, b_done);
            done_cnt += int'(b_done);
            if (t < 27) tick();
        end
        check("loop_b_done_count", 64'(done_cnt), 64'd3);
        check("abort_b_cur_before", 64'(b_cur), 64'd3);
        b_en = 1'b0;
        tick();
        check("abort_b_dout", 64'(b_dout), 64'd0);
        check("abort_b_cur", 64'(b_cur), 64'd0);
        check("abort_b_valid", 64'(b_val), 64'd0);
        b_en = 1'b1;
        for (int t = 0; t <= 2; t++) begin
            tick();
            check_sweep("restart_b", t, 3, 1, 1'b1, 1'b0, 1'b0, 64'(b_dout), 64'(b_cur), b_val, b_done);
        end

        // C: active-low, bit-reversed, SEL_W=4
        c_en = 1'b1; c_mode = 1'b0; c_sv = 1'b1; c_sel = 4'd2;
        tick();
        check("c_direct_dout_2", 64'(c_dout), 64'hDFFF);
        check("c_direct_cur_2", 64'(c_cur), 64'd2);
        c_sv = 1'b0; c_mode = 1'b1;
        tick();
        check("c_toggle_idle", 64'(c_dout), 64'hFFFF);
        tick();
        abort_t = int'($urandom_range(3, 25));
        for (int t = 0; t <= abort_t; t++) begin
            check_sweep("c_part", t, 4, 2, 1'b0, 1'b1, 1'b1, 64'(c_dout), 64'(c_cur), c_val, c_done);
            if (t < abort_t) tick();
        end
        c_en = 1'b0;
        tick();
        check("c_abort_dout", 64'(c_dout), 64'hFFFF);
        check("c_abort_cur", 64'(c_cur), 64'd0);
        c_en = 1'b1;
        tick();
        done_cnt = 0;
        for (int t = 0; t <= 36; t++) begin
            check_sweep("c_full", t, 4, 2, 1'b0, 1'b1, 1'b1, 64'(c_dout), 64'(c_cur), c_val, c_done);
            done_cnt += int'(c_done);
            if (t < 36) tick();
        end
        check("c_done_count", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
